lift_row_ctrl: RTL and testbench

Sequencer and port arbiter for the 26-bit pixel row buffer RAM in the fixbv lifting path. When started, it takes ownership of the RAM and performs one in-place 5/3 (LeGall) lifting pass over a row of N samples, forward or inverse. Each step reads the left, right and centre pixels, computes the lifted value and writes it back. While idle, it forwards a host port to the RAM transparently, so the host loads rows before a pass and unloads them afterwards.

---
 rtl/lift_row_ctrl_if.sv | 25 ++
 rtl/lift_row_ctrl.sv | 134 +++++++++++++
 tb/tb_lift_row_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/lift_row_ctrl_if.sv
// Host and RAM port bundle for the lifting row sequencer.
// master = sequencer side, slave = host/RAM side.
interface lift_row_ctrl_if #(
  parameter int W  = 26,
  parameter int AW = 7
);
  logic [AW-1:0] host_addr;
  logic [W-1:0]  host_din;
  logic          host_we;
  logic [W-1:0]  host_dout;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_din;
  logic          ram_we;
  logic [W-1:0]  ram_dout;

  modport master (
    input  host_addr, host_din, host_we, ram_dout,
    output host_dout, ram_addr, ram_din, ram_we
  );

  modport slave (
    output host_addr, host_din, host_we, ram_dout,
    input  host_dout, ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/lift_row_ctrl.sv
// In-place 5/3 (LeGall) lifting sequencer over a row RAM.
// Forwards the host port to the RAM while idle.
module lift_row_ctrl #(
  parameter int W  = 26,
  parameter int AW = 7,
  parameter int N  = 128
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic inverse,
  output logic busy,
  output logic done,
  lift_row_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD_L, RD_R, RD_C, WR, DONE} state_t;

  localparam logic [AW-1:0] C_LAST_ODD  = AW'(N - 1);
  localparam logic [AW-1:0] C_LAST_EVEN = AW'(N - 2);
  localparam logic signed [W+1:0] TWO   = (W+2)'(2);

  state_t        state, state_nx;
  logic          inv, inv_nx;
  logic          phase, phase_nx;
  logic [AW-1:0] c, c_nx;
  logic [W-1:0]  a, b;

  logic          odd_phase, sub;
  logic [AW-1:0] l_addr, r_addr, c_last;
  logic signed [W+1:0] sa, sb, sx, s, t, res;

  // Phase 0 is predict (odd c) for forward and update (even c) for inverse.
  assign odd_phase = (phase == inv);
  assign sub       = odd_phase ^ inv;
  assign c_last    = odd_phase ? C_LAST_ODD : C_LAST_EVEN;
  assign l_addr    = (c == '0) ? AW'(1) : c - AW'(1);
  assign r_addr    = (c == C_LAST_ODD) ? C_LAST_EVEN : c + AW'(1);

  // Sum kept two bits wider than a pixel so s+2 cannot overflow before the shift.
  always_comb begin
    sa  = {{2{a[W-1]}}, a};
    sb  = {{2{b[W-1]}}, b};
    sx  = {{2{bus.ram_dout[W-1]}}, bus.ram_dout};
    s   = sa + sb;
    t   = odd_phase ? (s >>> 1) : ((s + TWO) >>> 2);
    res = sub ? (sx - t) : (sx + t);
  end

  assign bus.host_dout = bus.ram_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      inv   <= 1'b0;
      phase <= 1'b0;
      c     <= '0;
      a     <= '0;
      b     <= '0;
    end else begin
      state <= state_nx;
      inv   <= inv_nx;
      phase <= phase_nx;
      c     <= c_nx;
      if (state == RD_R) a <= bus.ram_dout;
      if (state == RD_C) b <= bus.ram_dout;
    end
  end

  always_comb begin
    state_nx    = state;
    inv_nx      = inv;
    phase_nx    = phase;
    c_nx        = c;
    busy        = 1'b0;
    done        = 1'b0;
    bus.ram_addr = bus.host_addr;
    bus.ram_din  = bus.host_din;
    bus.ram_we   = bus.host_we;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RD_L;
          inv_nx   = inverse;
          phase_nx = 1'b0;
          c_nx     = {{(AW-1){1'b0}}, ~inverse};
        end
      end
      RD_L: begin
        busy         = 1'b1;
        bus.ram_addr = l_addr;
        bus.ram_din  = '0;
        bus.ram_we   = 1'b0;
        state_nx     = RD_R;
      end
      RD_R: begin
        busy         = 1'b1;
        bus.ram_addr = r_addr;
        bus.ram_din  = '0;
        bus.ram_we   = 1'b0;
        state_nx     = RD_C;
      end
      RD_C: begin
        busy         = 1'b1;
        bus.ram_addr = c;
        bus.ram_din  = '0;
        bus.ram_we   = 1'b0;
        state_nx     = WR;
      end
      WR: begin
        busy         = 1'b1;
        bus.ram_addr = c;
        bus.ram_din  = res[W-1:0];
        bus.ram_we   = 1'b1;
        if (c != c_last) begin
          c_nx     = c + AW'(2);
          state_nx = RD_L;
        end else if (phase) begin
          state_nx = DONE;
        end else begin
          phase_nx = 1'b1;
          c_nx     = {{(AW-1){1'b0}}, inv};
          state_nx = RD_L;
        end
      end
      DONE: begin
        done       = 1'b1;
        bus.ram_we = 1'b0;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (rst) bus.ram_we = 1'b0;
  end
endmodule

// File: tb/tb_lift_row_ctrl.sv
// Scoreboard bench for lift_row_ctrl with a behavioural 1-cycle-latency RAM.
module tb_lift_row_ctrl;
  localparam int W  = 26;
  localparam int AW = 7;
  localparam int N  = 128;

  logic clk = 1'b0;
  logic rst, start, inverse, busy, done;

  lift_row_ctrl_if #(.W(W), .AW(AW)) bus ();

  lift_row_ctrl #(.W(W), .AW(AW), .N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .inverse(inverse),
    .busy   (busy),
    .done   (done),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [N];
  always @(posedge clk) begin
    bus.ram_dout <= mem[bus.ram_addr];
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
  end

  int done_cnt = 0;
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  logic signed [W-1:0] model [N];
  logic signed [W-1:0] orig  [N];
  logic [W-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_row();
    for (int i = 0; i < N; i++) begin
      bus.host_addr = AW'(i);
      bus.host_din  = model[i];
      bus.host_we   = 1'b1;
      tick();
    end
    bus.host_we = 1'b0;
  endtask

  task automatic read_row(input string tag);
    for (int i = 0; i < N; i++) begin
      bus.host_addr = AW'(i);
      bus.host_we   = 1'b0;
      exp_q.push_back(model[i]);
      tick();
      chk($sformatf("%s[%0d]", tag, i), 64'(bus.host_dout), 64'(exp_q.pop_front()));
    end
  endtask

  // Sequential reference of the lifting pass, stopping after 'steps' writes.
  task automatic model_pass(input bit inv, input int steps);
    int n, l, r, c;
    bit odd;
    longint a, b, x, s, t, res;
    n = 0;
    for (int ph = 0; ph < 2; ph++) begin
      odd = (ph == 0) ? !inv : inv;
      for (c = odd ? 1 : 0; c < N; c += 2) begin
        if (n >= steps) return;
        n++;
        l = (c == 0) ? 1 : c - 1;
        r = (c == N - 1) ? N - 2 : c + 1;
        a = model[l];
        b = model[r];
        x = model[c];
        s = a + b;
        if (odd) begin
          t   = s >>> 1;
          res = inv ? x + t : x - t;
        end else begin
          t   = (s + 2) >>> 2;
          res = inv ? x - t : x + t;
        end
        model[c] = W'(res);
      end
    end
  endtask

  task automatic run_pass(input bit inv, input bit noise);
    int cyc, d0;
    d0      = done_cnt;
    start   = 1'b1;
    inverse = inv;
    tick();
    start = 1'b0;
    cyc   = 1;
    chk("busy_start", 64'(busy), 64'(1));
    while (!done && cyc < 8 * N) begin
      if (noise) begin
        bus.host_we   = 1'($urandom);
        bus.host_addr = AW'($urandom);
        bus.host_din  = W'($urandom);
        start         = (cyc % 50 == 0);
        inverse       = ~inv;
      end
      tick();
      cyc++;
    end
    start       = 1'b0;
    inverse     = 1'b0;
    bus.host_we = 1'b0;
    chk("done_cycle", 64'(cyc), 64'(4 * N + 1));
    chk("busy_at_done", 64'(busy), 64'(0));
    tick();
    chk("done_one_cycle", 64'(done), 64'(0));
    chk("done_count", 64'(done_cnt - d0), 64'(1));
  endtask

  initial begin
    logic signed [19:0] v;
    rst           = 1'b1;
    start         = 1'b0;
    inverse       = 1'b0;
    bus.host_addr = '0;
    bus.host_din  = '0;
    bus.host_we   = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_ram_we", 64'(bus.ram_we), 64'(0));
    bus.host_we = 1'b0;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk("start_in_rst_ignored", 64'(busy), 64'(0));

    for (int i = 0; i < N; i++) model[i] = 26'sd100;
    load_row();
    run_pass(1'b0, 1'b0);
    model_pass(1'b0, N);
    read_row("const");
    chk("const_odd", 64'(model[5]), 64'(0));
    chk("const_even", 64'(model[6]), 64'(100));

    for (int i = 0; i < N; i++) model[i] = W'(i);
    load_row();
    run_pass(1'b0, 1'b0);
    model_pass(1'b0, N);
    read_row("ramp");

    for (int i = 0; i < N; i++) begin
      v = 20'($urandom);
      model[i] = v;
    end
    orig = model;
    load_row();
    run_pass(1'b0, 1'b0);
    model_pass(1'b0, N);
    read_row("rt_fwd");
    run_pass(1'b1, 1'b0);
    model = orig;
    read_row("rt_inv");

    for (int i = 0; i < N; i++) model[i] = -26'sd3;
    load_row();
    run_pass(1'b0, 1'b0);
    model_pass(1'b0, N);
    read_row("neg3");

    for (int i = 0; i < N; i++)
      model[i] = (i % 2 == 0) ? 26'sh1FFFFFF : 26'sh2000000;
    load_row();
    run_pass(1'b0, 1'b0);
    model_pass(1'b0, N);
    read_row("wrap");

    for (int i = 0; i < N; i++) model[i] = W'($urandom);
    load_row();
    run_pass(1'b0, 1'b1);
    model_pass(1'b0, N);
    read_row("arb");

    for (int i = 0; i < N; i++) begin
      v = 20'($urandom);
      model[i] = v;
    end
    load_row();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (199) tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_we_now", 64'(bus.ram_we), 64'(0));
    tick();
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_done", 64'(done), 64'(0));
    chk("rst_mid_we", 64'(bus.ram_we), 64'(0));
    rst = 1'b0;
    model_pass(1'b0, 49);
    read_row("rst_partial");
    run_pass(1'b0, 1'b0);
    model_pass(1'b0, N);
    read_row("rst_fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
